// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve delay, PLAY-only ball fsync gating, wall hit/miss
// decisions, score keeping and winner detection for a single ball object.
module pong_game_ctrl #(
  parameter int HRES         = 1280,
  parameter int PADDLE_LEN   = 100,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 120,
  parameter int POINT_FRAMES = 60
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        fsync,
  input  logic        start,
  input  logic [11:0] ball_lh,
  input  logic [11:0] ball_rh,
  input  logic [11:0] ball_tv,
  input  logic [11:0] ball_bv,
  input  logic [11:0] pad_l_top,
  input  logic [11:0] pad_r_top,
  output logic        ball_rst,
  output logic        ball_fsync,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        hit_l,
  output logic        hit_r,
  output logic [1:0]  winner,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            start_q, start_pe;
  logic            serve_done, point_done, game_won;
  logic            at_left, at_right, hit_l_ok, hit_r_ok, play_eval;
  logic            left_hit, left_miss, right_hit, right_miss;
  logic signed [12:0] pad_l_bot, pad_r_bot, tv_ext;
  logic            ball_rst_nxt, hit_l_nxt, hit_r_nxt;
  logic [3:0]      score_l_nxt, score_r_nxt;
  logic [1:0]      winner_nxt;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'(WIN_SCORE)) ? s : s + 4'd1;
  endfunction

  assign start_pe   = start & ~start_q;
  assign serve_done = fsync && (cnt == CW'(SERVE_FRAMES - 1));
  assign point_done = fsync && (cnt == CW'(POINT_FRAMES - 1));
  assign game_won   = (score_l == 4'(WIN_SCORE)) || (score_r == 4'(WIN_SCORE));

  // Paddle bottom carried in 13 bits so a paddle near +2047 cannot wrap negative.
  assign pad_l_bot = $signed({pad_l_top[11], pad_l_top}) + $signed(13'(PADDLE_LEN - 1));
  assign pad_r_bot = $signed({pad_r_top[11], pad_r_top}) + $signed(13'(PADDLE_LEN - 1));
  assign tv_ext    = $signed({ball_tv[11], ball_tv});

  assign at_left   = $signed(ball_lh) <= 12'sd0;
  assign at_right  = $signed(ball_rh) >= $signed(12'(HRES - 1));
  assign hit_l_ok  = ($signed(ball_bv) >= $signed(pad_l_top)) && (tv_ext <= pad_l_bot);
  assign hit_r_ok  = ($signed(ball_bv) >= $signed(pad_r_top)) && (tv_ext <= pad_r_bot);
  assign play_eval = (state == ST_PLAY) && fsync;

  // Left wall takes priority when both walls are touched in the same frame.
  assign left_hit   = play_eval && at_left && hit_l_ok;
  assign left_miss  = play_eval && at_left && !hit_l_ok;
  assign right_hit  = play_eval && !at_left && at_right && hit_r_ok;
  assign right_miss = play_eval && !at_left && at_right && !hit_r_ok;

  assign ball_fsync = fsync && (state == ST_PLAY);
  assign state_o    = state;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= start;
      if (state_nxt != state) cnt <= '0;
      else if (fsync)         cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start_pe)                 state_nxt = ST_SERVE;
      ST_SERVE: if (serve_done)               state_nxt = ST_PLAY;
      ST_PLAY:  if (left_miss || right_miss)  state_nxt = ST_POINT;
      ST_POINT: if (point_done)               state_nxt = game_won ? ST_OVER : ST_SERVE;
      ST_OVER:  if (start_pe)                 state_nxt = ST_IDLE;
      default:                                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ball_rst_nxt = (state_nxt != ST_PLAY);
    hit_l_nxt    = left_hit;
    hit_r_nxt    = right_hit;
    score_l_nxt  = score_l;
    score_r_nxt  = score_r;
    winner_nxt   = winner;
    if (state == ST_IDLE && start_pe) begin
      score_l_nxt = 4'd0;
      score_r_nxt = 4'd0;
      winner_nxt  = 2'b00;
    end
    if (right_miss) score_l_nxt = sat_inc(score_l);
    if (left_miss)  score_r_nxt = sat_inc(score_r);
    if (state == ST_POINT && state_nxt == ST_OVER)
      winner_nxt = (score_l == 4'(WIN_SCORE)) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      ball_rst <= 1'b1;
      hit_l    <= 1'b0;
      hit_r    <= 1'b0;
      score_l  <= 4'd0;
      score_r  <= 4'd0;
      winner   <= 2'b00;
    end else begin
      ball_rst <= ball_rst_nxt;
      hit_l    <= hit_l_nxt;
      hit_r    <= hit_r_nxt;
      score_l  <= score_l_nxt;
      score_r  <= score_r_nxt;
      winner   <= winner_nxt;
    end
  end

endmodule
